// File: rtl/tetris_pkg.sv
// Shared Tetris definitions: field geometry, move codes, block descriptor and
// the tetromino rotation table used by the move engine.
package tetris_pkg;

  localparam int FIELD_ROW_CNT       = 20;
  localparam int FIELD_COL_CNT       = 10;
  localparam int EXT_ROW             = FIELD_ROW_CNT + 1;
  localparam int EXT_COL             = FIELD_COL_CNT + 2;
  localparam int TETRIS_COLORS_WIDTH = 4;
  localparam int X_W                 = 4;
  localparam int Y_W                 = 5;

  typedef enum logic [2:0] {
    MOVE_LEFT,
    MOVE_RIGHT,
    MOVE_DOWN,
    MOVE_ROTATE,
    MOVE_APPEAR
  } move_t;

  typedef enum logic [1:0] {
    CHK_IDLE,
    CHK_EVAL,
    CHK_REPORT
  } chk_state_t;

  // data[rotation][row][col]; each rotation is a row-major 4x4 with col 0 as MSB
  typedef logic [0:3][0:3][0:3] block_data_t;

  typedef struct packed {
    block_data_t                    data;
    logic [1:0]                     rotation;
    logic [X_W-1:0]                 x;
    logic [Y_W-1:0]                 y;
    logic [TETRIS_COLORS_WIDTH-1:0] color;
  } block_info_t;

  typedef logic [EXT_ROW-1:0][EXT_COL-1:0] field_t;

  function automatic block_data_t shape_data(input logic [2:0] idx);
    case (idx)
      3'd0:    return {16'h0F00, 16'h2222, 16'h00F0, 16'h4444};
      3'd1:    return {16'h6600, 16'h6600, 16'h6600, 16'h6600};
      3'd2:    return {16'h4E00, 16'h4640, 16'h0E40, 16'h4C40};
      3'd3:    return {16'h6C00, 16'h4620, 16'h06C0, 16'h8C40};
      3'd4:    return {16'hC600, 16'h2640, 16'h0C60, 16'h4C80};
      3'd5:    return {16'h8E00, 16'h6440, 16'h0E20, 16'h44C0};
      default: return {16'h2E00, 16'h4460, 16'h0E80, 16'hC440};
    endcase
  endfunction

  // Colour 0 is empty and 1 is wall, so shapes start at 2
  function automatic block_info_t spawn_block(input logic [15:0] lfsr);
    block_info_t b;
    logic [2:0]  idx;
    idx        = (lfsr[2:0] == 3'd7) ? 3'd0 : lfsr[2:0];
    b.data     = shape_data(idx);
    b.rotation = 2'd0;
    b.x        = X_W'(EXT_COL / 2 - 2);
    b.y        = '0;
    b.color    = {1'b0, idx} + 4'd2;
    return b;
  endfunction

  function automatic logic signed [1:0] move_dx(input move_t m);
    case (m)
      MOVE_LEFT:  return -2'sd1;
      MOVE_RIGHT: return 2'sd1;
      default:    return 2'sd0;
    endcase
  endfunction

  function automatic logic signed [1:0] move_dy(input move_t m);
    return (m == MOVE_DOWN) ? 2'sd1 : 2'sd0;
  endfunction

endpackage

// File: rtl/tetris_move_engine_if.sv
// Bundle between the game FSM (master) and the move engine (slave).
interface tetris_move_engine_if;
  import tetris_pkg::*;

  logic               run_i;
  move_t              req_move_i;
  block_info_t        block_i;
  field_t             field_i;
  logic               done_o;
  logic               can_move_o;
  logic signed [1:0]  move_x_o;
  logic signed [1:0]  move_y_o;
  logic               next_en_i;
  block_info_t        next_block_o;
  logic               sys_srst_i;
  logic               level_changed_i;
  logic               sys_event_o;

  modport master (
    output run_i, req_move_i, block_i, field_i, next_en_i, sys_srst_i, level_changed_i,
    input  done_o, can_move_o, move_x_o, move_y_o, next_block_o, sys_event_o
  );

  modport slave (
    input  run_i, req_move_i, block_i, field_i, next_en_i, sys_srst_i, level_changed_i,
    output done_o, can_move_o, move_x_o, move_y_o, next_block_o, sys_event_o
  );

endinterface

// File: rtl/tetris_move_checker.sv
// Collision check of one requested move: latch, evaluate the 4x4 candidate,
// then report with a one-cycle done pulse two cycles after run.
module tetris_move_checker
  import tetris_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              run_i,
  input  move_t             req_move_i,
  input  block_info_t       block_i,
  input  field_t            field_i,
  output logic              done_o,
  output logic              can_move_o,
  output logic signed [1:0] move_x_o,
  output logic signed [1:0] move_y_o
);

  localparam int XI = X_W + 1;
  localparam int YI = Y_W + 1;
  localparam logic signed [XI-1:0] COL_LIM = XI'(EXT_COL);
  localparam logic signed [YI-1:0] ROW_LIM = YI'(EXT_ROW);

  chk_state_t state, state_nxt;
  logic       report_c;

  block_data_t       lat_data;
  logic [1:0]        lat_rot;
  logic [X_W-1:0]    lat_x;
  logic [Y_W-1:0]    lat_y;
  field_t            lat_field;
  logic signed [1:0] lat_dx, lat_dy;
  logic              hit_c, hit_q;

  logic signed [XI-1:0] base_col, col;
  logic signed [YI-1:0] base_row, row;

  logic unused_color;
  assign unused_color = ^block_i.color;

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= CHK_IDLE;
    else       state <= state_nxt;
  end

  // A new run always restarts the sequence and cancels a pending report
  always_comb begin
    state_nxt = state;
    report_c  = 1'b0;
    if (run_i) begin
      state_nxt = CHK_EVAL;
    end else begin
      case (state)
        CHK_EVAL:   state_nxt = CHK_REPORT;
        CHK_REPORT: begin
          state_nxt = CHK_IDLE;
          report_c  = 1'b1;
        end
        default:    state_nxt = CHK_IDLE;
      endcase
    end
  end

  assign base_col = $signed({1'b0, lat_x}) + XI'(lat_dx);
  assign base_row = $signed({1'b0, lat_y}) + YI'(lat_dy);

  always_comb begin
    hit_c = 1'b0;
    col   = '0;
    row   = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        col = base_col + XI'(c);
        row = base_row + YI'(r);
        if (lat_data[lat_rot][r][c]) begin
          if (col[XI-1] || col >= COL_LIM || row[YI-1] || row >= ROW_LIM)
            hit_c = 1'b1;
          else if (lat_field[row[Y_W-1:0]][col[X_W-1:0]])
            hit_c = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lat_data   <= '0;
      lat_rot    <= '0;
      lat_x      <= '0;
      lat_y      <= '0;
      lat_field  <= '0;
      lat_dx     <= '0;
      lat_dy     <= '0;
      hit_q      <= 1'b0;
      done_o     <= 1'b0;
      can_move_o <= 1'b0;
      move_x_o   <= '0;
      move_y_o   <= '0;
    end else begin
      if (run_i) begin
        lat_data  <= block_i.data;
        lat_rot   <= (req_move_i == MOVE_ROTATE) ? block_i.rotation + 2'd1 : block_i.rotation;
        lat_x     <= block_i.x;
        lat_y     <= block_i.y;
        lat_field <= field_i;
        lat_dx    <= move_dx(req_move_i);
        lat_dy    <= move_dy(req_move_i);
      end
      if (state == CHK_EVAL) hit_q <= hit_c;
      done_o <= report_c;
      if (report_c) begin
        can_move_o <= ~hit_q;
        move_x_o   <= lat_dx;
        move_y_o   <= lat_dy;
      end
    end
  end

endmodule

// File: rtl/tetris_move_engine.sv
// Move/timing helper for the game FSM: collision checker, next-block LFSR
// and level-dependent gravity tick.
module tetris_move_engine
  import tetris_pkg::*;
#(
  parameter int          TICK_INIT = 25_000_000,
  parameter int          TICK_STEP = 2_500_000,
  parameter int          TICK_MIN  = 2_500_000,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input logic                 clk_i,
  input logic                 rst_i,
  tetris_move_engine_if.slave bus
);

  localparam int CNT_W = $clog2(TICK_INIT + 1);
  localparam logic [CNT_W-1:0] P_INIT  = CNT_W'(TICK_INIT);
  localparam logic [CNT_W-1:0] P_STEP  = CNT_W'(TICK_STEP);
  localparam logic [CNT_W-1:0] P_MIN   = CNT_W'(TICK_MIN);
  localparam logic [CNT_W-1:0] P_SAT   = CNT_W'(TICK_MIN + TICK_STEP);
  localparam logic [CNT_W-1:0] P_ONE   = CNT_W'(1);

  logic [15:0]      lfsr, lfsr_nxt;
  block_info_t      next_block_q;
  logic [CNT_W-1:0] tick_cnt, tick_period;
  logic             tick_q;

  tetris_move_checker u_checker (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .run_i      (bus.run_i),
    .req_move_i (bus.req_move_i),
    .block_i    (bus.block_i),
    .field_i    (bus.field_i),
    .done_o     (bus.done_o),
    .can_move_o (bus.can_move_o),
    .move_x_o   (bus.move_x_o),
    .move_y_o   (bus.move_y_o)
  );

  // Right-shifting Galois form of the x^16+x^14+x^13+x^11+1 polynomial
  assign lfsr_nxt = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lfsr         <= LFSR_SEED;
      next_block_q <= spawn_block(LFSR_SEED);
    end else if (bus.next_en_i) begin
      lfsr         <= lfsr_nxt;
      next_block_q <= spawn_block(lfsr_nxt);
    end
  end

  assign bus.next_block_o = next_block_q;

  // ">=" keeps the tick alive if a speed-up shrinks the period below the count
  always_ff @(posedge clk_i) begin
    if (rst_i || bus.sys_srst_i) begin
      tick_cnt    <= '0;
      tick_period <= P_INIT;
      tick_q      <= 1'b0;
    end else begin
      if (bus.level_changed_i)
        tick_period <= (tick_period >= P_SAT) ? tick_period - P_STEP : P_MIN;
      if (tick_cnt >= tick_period - P_ONE) begin
        tick_cnt <= '0;
        tick_q   <= 1'b1;
      end else begin
        tick_cnt <= tick_cnt + P_ONE;
        tick_q   <= 1'b0;
      end
    end
  end

  assign bus.sys_event_o = tick_q;

endmodule

// File: tb/tb_tetris_move_engine.sv
// Directed self-checking bench for tetris_move_engine with a shortened gravity period.
module tb_tetris_move_engine;
  import tetris_pkg::*;

  logic clk_i = 1'b0;
  logic rst_i;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk_i = ~clk_i;

  tetris_move_engine_if bus();

  tetris_move_engine #(
    .TICK_INIT (10),
    .TICK_STEP (3),
    .TICK_MIN  (4),
    .LFSR_SEED (16'hACE1)
  ) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  function automatic block_info_t mk(input logic [63:0] d, input logic [1:0] rot,
                                     input logic [3:0] x, input logic [4:0] y);
    block_info_t b;
    b.data     = d;
    b.rotation = rot;
    b.x        = x;
    b.y        = y;
    b.color    = 4'd2;
    return b;
  endfunction

  function automatic field_t walled();
    field_t f;
    f = '0;
    for (int r = 0; r < EXT_ROW; r++) begin
      f[r][0]  = 1'b1;
      f[r][11] = 1'b1;
    end
    f[20] = '1;
    return f;
  endfunction

  // Issues one run pulse and returns the number of edges until done (99 = never)
  task automatic issue_check(input move_t m, input block_info_t b, input field_t f, output int lat);
    @(negedge clk_i);
    bus.req_move_i = m;
    bus.block_i    = b;
    bus.field_i    = f;
    bus.run_i      = 1'b1;
    @(negedge clk_i);
    bus.run_i = 1'b0;
    lat = 99;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk_i);
      if (bus.done_o) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic wait_pulse(output int n);
    n = 0;
    do begin
      @(posedge clk_i);
      #1;
      n++;
    end while (!bus.sys_event_o && n < 40);
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    checks++; if (bus.done_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_done: got %0b expected 0", bus.done_o); end
    checks++; if (bus.can_move_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_can: got %0b expected 0", bus.can_move_o); end
    checks++; if (bus.move_x_o !== 2'b00 || bus.move_y_o !== 2'b00) begin failures++; $display("[TB] FAIL reset_moves: got %0d,%0d expected 0,0", bus.move_x_o, bus.move_y_o); end
    checks++; if (bus.sys_event_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_event: got %0b expected 0", bus.sys_event_o); end
    checks++; if (bus.next_block_o.color !== 4'd3) begin failures++; $display("[TB] FAIL reset_color: got %0d expected 3", bus.next_block_o.color); end
    checks++; if (bus.next_block_o.data[0] !== 16'h6600) begin failures++; $display("[TB] FAIL reset_shape: got %h expected 6600", bus.next_block_o.data[0]); end
    checks++; if (bus.next_block_o.x !== 4'd4 || bus.next_block_o.y !== 5'd0) begin failures++; $display("[TB] FAIL reset_pos: got %0d,%0d expected 4,0", bus.next_block_o.x, bus.next_block_o.y); end
    rst_i = 1'b0;
  endtask

  task automatic test_move_down();
    int lat;
    issue_check(MOVE_DOWN, mk({4{16'h6600}}, 2'd0, 4'd4, 5'd0), walled(), lat);
    checks++; if (lat !== 2) begin failures++; $display("[TB] FAIL down_latency: got %0d expected 2", lat); end
    checks++; if (bus.can_move_o !== 1'b1) begin failures++; $display("[TB] FAIL down_can: got %0b expected 1", bus.can_move_o); end
    checks++; if (bus.move_x_o !== 2'sd0 || bus.move_y_o !== 2'sd1) begin failures++; $display("[TB] FAIL down_delta: got %0d,%0d expected 0,1", bus.move_x_o, bus.move_y_o); end
    @(negedge clk_i);
    checks++; if (bus.done_o !== 1'b0) begin failures++; $display("[TB] FAIL down_pulse: got %0b expected 0", bus.done_o); end
  endtask

  task automatic test_wall_left();
    int lat;
    issue_check(MOVE_LEFT, mk({4{16'h4444}}, 2'd0, 4'd0, 5'd5), walled(), lat);
    checks++; if (lat !== 2 || bus.can_move_o !== 1'b0) begin failures++; $display("[TB] FAIL left_wall: got lat=%0d can=%0b expected lat=2 can=0", lat, bus.can_move_o); end
    checks++; if (bus.move_x_o !== -2'sd1 || bus.move_y_o !== 2'sd0) begin failures++; $display("[TB] FAIL left_delta: got %0d,%0d expected -1,0", bus.move_x_o, bus.move_y_o); end
    issue_check(MOVE_RIGHT, mk({4{16'h4444}}, 2'd0, 4'd0, 5'd5), walled(), lat);
    checks++; if (bus.can_move_o !== 1'b1 || bus.move_x_o !== 2'sd1) begin failures++; $display("[TB] FAIL right_free: got can=%0b dx=%0d expected can=1 dx=1", bus.can_move_o, bus.move_x_o); end
  endtask

  task automatic test_floor();
    int lat;
    issue_check(MOVE_DOWN, mk({4{16'h4E00}}, 2'd0, 4'd4, 5'd18), walled(), lat);
    checks++; if (bus.can_move_o !== 1'b0 || bus.move_y_o !== 2'sd1) begin failures++; $display("[TB] FAIL floor_hit: got can=%0b dy=%0d expected can=0 dy=1", bus.can_move_o, bus.move_y_o); end
    issue_check(MOVE_DOWN, mk({4{16'h4E00}}, 2'd0, 4'd4, 5'd17), walled(), lat);
    checks++; if (bus.can_move_o !== 1'b1) begin failures++; $display("[TB] FAIL floor_above: got %0b expected 1", bus.can_move_o); end
  endtask

  task automatic test_bounds();
    int lat;
    issue_check(MOVE_RIGHT, mk({4{16'h1111}}, 2'd0, 4'd8, 5'd5), '0, lat);
    checks++; if (bus.can_move_o !== 1'b0) begin failures++; $display("[TB] FAIL bound_right_out: got %0b expected 0", bus.can_move_o); end
    issue_check(MOVE_RIGHT, mk({4{16'h1111}}, 2'd0, 4'd7, 5'd5), '0, lat);
    checks++; if (bus.can_move_o !== 1'b1) begin failures++; $display("[TB] FAIL bound_right_in: got %0b expected 1", bus.can_move_o); end
    issue_check(MOVE_LEFT, mk({4{16'h8888}}, 2'd0, 4'd0, 5'd5), '0, lat);
    checks++; if (bus.can_move_o !== 1'b0) begin failures++; $display("[TB] FAIL bound_left_neg: got %0b expected 0", bus.can_move_o); end
    issue_check(MOVE_DOWN, mk({4{16'hF000}}, 2'd0, 4'd0, 5'd20), '0, lat);
    checks++; if (bus.can_move_o !== 1'b0) begin failures++; $display("[TB] FAIL bound_bottom_out: got %0b expected 0", bus.can_move_o); end
    issue_check(MOVE_DOWN, mk({4{16'hF000}}, 2'd0, 4'd0, 5'd19), '0, lat);
    checks++; if (bus.can_move_o !== 1'b1) begin failures++; $display("[TB] FAIL bound_bottom_in: got %0b expected 1", bus.can_move_o); end
  endtask

  task automatic test_rotate_appear();
    int     lat;
    field_t top_full;
    logic [63:0] d;
    d = {16'h6600, 16'h8888, 16'h8888, 16'h8888};
    issue_check(MOVE_ROTATE, mk(d, 2'd3, 4'd0, 5'd5), walled(), lat);
    checks++; if (bus.can_move_o !== 1'b1 || bus.move_x_o !== 2'sd0 || bus.move_y_o !== 2'sd0) begin failures++; $display("[TB] FAIL rotate_wrap: got can=%0b d=%0d,%0d expected can=1 d=0,0", bus.can_move_o, bus.move_x_o, bus.move_y_o); end
    issue_check(MOVE_ROTATE, mk(d, 2'd0, 4'd0, 5'd5), walled(), lat);
    checks++; if (bus.can_move_o !== 1'b0) begin failures++; $display("[TB] FAIL rotate_next: got %0b expected 0", bus.can_move_o); end
    issue_check(MOVE_APPEAR, mk(d, 2'd0, 4'd0, 5'd5), walled(), lat);
    checks++; if (bus.can_move_o !== 1'b1) begin failures++; $display("[TB] FAIL appear_current: got %0b expected 1", bus.can_move_o); end
    top_full = walled();
    top_full[0] = '1;
    top_full[1] = '1;
    issue_check(MOVE_APPEAR, mk({4{16'h6600}}, 2'd0, 4'd4, 5'd0), top_full, lat);
    checks++; if (bus.can_move_o !== 1'b0 || bus.move_y_o !== 2'sd0) begin failures++; $display("[TB] FAIL appear_blocked: got can=%0b dy=%0d expected can=0 dy=0", bus.can_move_o, bus.move_y_o); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk_i);
    bus.req_move_i = MOVE_LEFT;
    bus.block_i    = mk({4{16'h4444}}, 2'd0, 4'd0, 5'd5);
    bus.field_i    = walled();
    bus.run_i      = 1'b1;
    @(negedge clk_i);
    bus.req_move_i = MOVE_DOWN;
    bus.block_i    = mk({4{16'h6600}}, 2'd0, 4'd4, 5'd0);
    @(negedge clk_i);
    bus.run_i = 1'b0;
    checks++; if (bus.done_o !== 1'b0) begin failures++; $display("[TB] FAIL b2b_early: got %0b expected 0", bus.done_o); end
    @(negedge clk_i);
    checks++; if (bus.done_o !== 1'b0) begin failures++; $display("[TB] FAIL b2b_aborted: got %0b expected 0", bus.done_o); end
    @(negedge clk_i);
    checks++; if (bus.done_o !== 1'b1 || bus.can_move_o !== 1'b1 || bus.move_y_o !== 2'sd1) begin failures++; $display("[TB] FAIL b2b_second: got done=%0b can=%0b dy=%0d expected 1,1,1", bus.done_o, bus.can_move_o, bus.move_y_o); end
    repeat (3) @(negedge clk_i);
    checks++; if (bus.done_o !== 1'b0 || bus.can_move_o !== 1'b1 || bus.move_x_o !== 2'sd0 || bus.move_y_o !== 2'sd1) begin failures++; $display("[TB] FAIL b2b_hold: got done=%0b can=%0b d=%0d,%0d expected 0,1,0,1", bus.done_o, bus.can_move_o, bus.move_x_o, bus.move_y_o); end
  endtask

  task automatic test_next_block();
    logic [3:0]  exp_color [7] = '{4'd2, 4'd2, 4'd6, 4'd8, 4'd2, 4'd5, 4'd3};
    logic [15:0] exp_shape [7] = '{16'h0F00, 16'h0F00, 16'hC600, 16'h2E00, 16'h0F00, 16'h6C00, 16'h6600};
    @(negedge clk_i);
    bus.next_en_i = 1'b1;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk_i);
      checks++; if (bus.next_block_o.color !== exp_color[k]) begin failures++; $display("[TB] FAIL next_color[%0d]: got %0d expected %0d", k, bus.next_block_o.color, exp_color[k]); end
      checks++; if (bus.next_block_o.data[0] !== exp_shape[k]) begin failures++; $display("[TB] FAIL next_shape[%0d]: got %h expected %h", k, bus.next_block_o.data[0], exp_shape[k]); end
      checks++; if (bus.next_block_o.x !== 4'd4 || bus.next_block_o.y !== 5'd0 || bus.next_block_o.rotation !== 2'd0) begin failures++; $display("[TB] FAIL next_pos[%0d]: got x=%0d y=%0d rot=%0d expected 4,0,0", k, bus.next_block_o.x, bus.next_block_o.y, bus.next_block_o.rotation); end
    end
    bus.next_en_i = 1'b0;
    repeat (2) @(negedge clk_i);
    checks++; if (bus.next_block_o.color !== 4'd3) begin failures++; $display("[TB] FAIL next_hold: got %0d expected 3", bus.next_block_o.color); end
  endtask

  task automatic test_gravity();
    int n;
    @(negedge clk_i);
    bus.sys_srst_i = 1'b1;
    @(negedge clk_i);
    bus.sys_srst_i = 1'b0;
    wait_pulse(n);
    checks++; if (n !== 10) begin failures++; $display("[TB] FAIL grav_first: got %0d expected 10", n); end
    wait_pulse(n);
    checks++; if (n !== 10) begin failures++; $display("[TB] FAIL grav_period10: got %0d expected 10", n); end
    bus.level_changed_i = 1'b1;
    repeat (2) begin @(posedge clk_i); #1; end
    bus.level_changed_i = 1'b0;
    wait_pulse(n);
    checks++; if (n + 2 !== 4) begin failures++; $display("[TB] FAIL grav_after_level: got %0d expected 4", n + 2); end
    wait_pulse(n);
    checks++; if (n !== 4) begin failures++; $display("[TB] FAIL grav_period_min: got %0d expected 4", n); end
    repeat (3) begin @(posedge clk_i); #1; end
    bus.sys_srst_i      = 1'b1;
    bus.level_changed_i = 1'b1;
    @(posedge clk_i); #1;
    bus.sys_srst_i      = 1'b0;
    bus.level_changed_i = 1'b0;
    checks++; if (bus.sys_event_o !== 1'b0) begin failures++; $display("[TB] FAIL grav_srst_nopulse: got %0b expected 0", bus.sys_event_o); end
    wait_pulse(n);
    checks++; if (n !== 10) begin failures++; $display("[TB] FAIL grav_srst_restart: got %0d expected 10", n); end
    wait_pulse(n);
    checks++; if (n !== 10) begin failures++; $display("[TB] FAIL grav_srst_period: got %0d expected 10", n); end
  endtask

  initial begin
    rst_i               = 1'b1;
    bus.run_i           = 1'b0;
    bus.req_move_i      = MOVE_LEFT;
    bus.block_i         = '0;
    bus.field_i         = '0;
    bus.next_en_i       = 1'b0;
    bus.sys_srst_i      = 1'b0;
    bus.level_changed_i = 1'b0;
    test_reset();
    test_move_down();
    test_wall_left();
    test_floor();
    test_bounds();
    test_rotate_appear();
    test_back_to_back();
    test_next_block();
    test_gravity();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
